// File: rtl/sha_seq_pkg.sv
// Shared definitions for the sha256 block sequencer: core register map, CTRL bits, FSM states.
// SHA_SEQ_MODE224_EN selects the 7-word SHA-224 digest count when mode224 is set.
package sha_seq_pkg;

    localparam logic [7:0] AddrCtrl   = 8'h08;
    localparam logic [7:0] AddrStatus = 8'h09;
    localparam logic [7:0] AddrBlock  = 8'h10;
    localparam logic [7:0] AddrDigest = 8'h20;

    localparam int unsigned CtrlInitBit    = 0;
    localparam int unsigned CtrlNextBit    = 1;
    localparam int unsigned CtrlModeBit    = 2;
    localparam int unsigned StatusReadyBit = 0;

    // Index of the final digest word (N-1) for each mode.
    localparam logic [2:0] DigestLast256 = 3'd7;
    localparam logic [2:0] DigestLast224 = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCtrl,
        StSettle,
        StPoll,
        StDrd,
        StDout
    } state_e;

    typedef struct packed {
        logic        cs;
        logic        we;
        logic [7:0]  address;
        logic [31:0] write_data;
    } bus_t;

    localparam bus_t BusIdle = '0;

    function automatic bus_t bus_write(input logic [7:0] address, input logic [31:0] data);
        bus_t b;
        b.cs         = 1'b1;
        b.we         = 1'b1;
        b.address    = address;
        b.write_data = data;
        return b;
    endfunction

    function automatic bus_t bus_read(input logic [7:0] address);
        bus_t b;
        b.cs         = 1'b1;
        b.we         = 1'b0;
        b.address    = address;
        b.write_data = '0;
        return b;
    endfunction

endpackage

// File: rtl/sha_seq_watchdog.sv
// Status-poll watchdog: counts unanswered polls and flags the POLL_TIMEOUT-th one.
module sha_seq_watchdog #(
    parameter int unsigned POLL_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(POLL_TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // expired marks the poll currently being judged as the final allowed one.
    assign expired = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sha_seq.sv
// Streams 16-word blocks into the sha256 core, sequences init/next, polls status and returns
// the digest. Define SHA_SEQ_MODE224_EN to add the mode224 port (SHA-224, 7 digest words).
module sha_seq
    import sha_seq_pkg::*;
#(
    parameter int unsigned POLL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_first,
    input  logic        in_last,
    output logic        dig_valid,
    input  logic        dig_ready,
    output logic [31:0] dig_data,
    output logic        dig_last,
    output logic        busy,
    output logic        err,
    output logic        sha_cs,
    output logic        sha_we,
    output logic [7:0]  sha_address,
    output logic [31:0] sha_write_data,
    input  logic [31:0] sha_read_data,
    input  logic        sha_error
`ifdef SHA_SEQ_MODE224_EN
   ,input  logic        mode224
`endif
);

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        settle_q, settle_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        chain_open_q, chain_open_d;
    logic        err_q, err_d;
    logic [31:0] dig_q, dig_d;
    bus_t        bus_q, bus_d;
    logic        ready_en_q;

    logic        accept;
    logic        poll_seen;
    logic        poll_ready;
    logic        use_init;
    logic        mode_bit;
    logic [2:0]  dig_last_idx;
    logic [31:0] ctrl_word;
    logic        wd_clear, wd_enable, wd_expired;

`ifdef SHA_SEQ_MODE224_EN
    logic mode224_q, mode224_d;
    assign mode_bit     = !mode224_q;
    assign dig_last_idx = mode224_q ? DigestLast224 : DigestLast256;
`else
    assign mode_bit     = 1'b1;
    assign dig_last_idx = DigestLast256;
`endif

    // ready_en_q holds in_ready low through reset and for the first cycle after it.
    assign in_ready   = ready_en_q && ((state_q == StIdle) || (state_q == StLoad));
    assign accept     = in_valid && in_ready;
    assign poll_seen  = bus_q.cs && !bus_q.we && (bus_q.address == AddrStatus);
    assign poll_ready = poll_seen && sha_read_data[StatusReadyBit];
    assign use_init   = first_q || !chain_open_q;

    always_comb begin
        ctrl_word              = '0;
        ctrl_word[CtrlInitBit] = use_init;
        ctrl_word[CtrlNextBit] = !use_init;
        ctrl_word[CtrlModeBit] = mode_bit;
    end

    sha_seq_watchdog #(
        .POLL_TIMEOUT (POLL_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        settle_d     = settle_q;
        dcnt_d       = dcnt_q;
        first_d      = first_q;
        last_d       = last_q;
        chain_open_d = chain_open_q;
        err_d        = err_q | sha_error;
        dig_d        = dig_q;
        bus_d        = BusIdle;
        wd_clear     = 1'b1;
        wd_enable    = 1'b0;
`ifdef SHA_SEQ_MODE224_EN
        mode224_d    = mode224_q;
`endif

        unique case (state_q)
            StIdle, StLoad: begin
                if (accept) begin
                    bus_d  = bus_write(AddrBlock | {4'h0, wcnt_q}, in_data);
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == 4'd0) begin
                        first_d = in_first;
                        state_d = StLoad;
`ifdef SHA_SEQ_MODE224_EN
                        if (in_first || !chain_open_q) begin
                            mode224_d = mode224;
                        end
`endif
                    end
                    if (wcnt_q == 4'd15) begin
                        last_d  = in_last;
                        state_d = StCtrl;
                    end
                end
            end
            StCtrl: begin
                bus_d        = bus_write(AddrCtrl, ctrl_word);
                chain_open_d = 1'b1;
                settle_d     = 1'b0;
                state_d      = StSettle;
            end
            StSettle: begin
                settle_d = 1'b1;
                if (settle_q) begin
                    settle_d = 1'b0;
                    state_d  = StPoll;
                end
            end
            StPoll: begin
                wd_clear = 1'b0;
                bus_d    = bus_read(AddrStatus);
                if (poll_ready) begin
                    dcnt_d  = '0;
                    bus_d   = last_q ? bus_read(AddrDigest) : BusIdle;
                    state_d = last_q ? StDrd : StIdle;
                end else if (poll_seen) begin
                    if (wd_expired) begin
                        err_d        = 1'b1;
                        chain_open_d = 1'b0;
                        bus_d        = BusIdle;
                        state_d      = StIdle;
                    end else begin
                        wd_enable = 1'b1;
                    end
                end
            end
            StDrd: begin
                dig_d   = sha_read_data;
                state_d = StDout;
            end
            StDout: begin
                if (dig_ready) begin
                    if (dcnt_q == dig_last_idx) begin
                        chain_open_d = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        dcnt_d  = dcnt_q + 3'd1;
                        bus_d   = bus_read(AddrDigest | {5'b0, dcnt_q + 3'd1});
                        state_d = StDrd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wcnt_q       <= '0;
            settle_q     <= 1'b0;
            dcnt_q       <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            chain_open_q <= 1'b0;
            err_q        <= 1'b0;
            dig_q        <= '0;
            bus_q        <= BusIdle;
            ready_en_q   <= 1'b0;
`ifdef SHA_SEQ_MODE224_EN
            mode224_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            settle_q     <= settle_d;
            dcnt_q       <= dcnt_d;
            first_q      <= first_d;
            last_q       <= last_d;
            chain_open_q <= chain_open_d;
            err_q        <= err_d;
            dig_q        <= dig_d;
            bus_q        <= bus_d;
            ready_en_q   <= 1'b1;
`ifdef SHA_SEQ_MODE224_EN
            mode224_q    <= mode224_d;
`endif
        end
    end

    assign busy           = (state_q != StIdle);
    assign err            = err_q;
    assign dig_valid      = (state_q == StDout);
    assign dig_last       = dig_valid && (dcnt_q == dig_last_idx);
    assign dig_data       = dig_q;
    assign sha_cs         = bus_q.cs;
    assign sha_we         = bus_q.we;
    assign sha_address    = bus_q.address;
    assign sha_write_data = bus_q.write_data;

endmodule

// File: tb/tb_sha_seq.sv
// Bench for sha_seq: behavioural sha256 core stub plus write/digest scoreboards.
module tb_sha_seq;

    localparam int unsigned Timeout = 4;
    localparam int          CoreLatency = 4;
    localparam int          Budget = 300;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [0:7][31:0] Iv256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [0:7][31:0] Iv224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [0:7][31:0] DigAbc = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [0:7][31:0] DigTwo = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    localparam logic [0:7][31:0] Dig224 = {
        32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
        32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        dig_ready = 1'b1, sha_error = 1'b0;
    logic        in_ready, dig_valid, dig_last, busy, err, sha_cs, sha_we;
    logic [31:0] dig_data, sha_write_data, sha_read_data;
    logic [7:0]  sha_address;
`ifdef SHA_SEQ_MODE224_EN
    logic        mode224 = 1'b0;
`endif

    always #5 clk = ~clk;

    sha_seq #(
        .POLL_TIMEOUT (Timeout)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_first       (in_first),
        .in_last        (in_last),
        .dig_valid      (dig_valid),
        .dig_ready      (dig_ready),
        .dig_data       (dig_data),
        .dig_last       (dig_last),
        .busy           (busy),
        .err            (err),
        .sha_cs         (sha_cs),
        .sha_we         (sha_we),
        .sha_address    (sha_address),
        .sha_write_data (sha_write_data),
        .sha_read_data  (sha_read_data),
        .sha_error      (sha_error)
`ifdef SHA_SEQ_MODE224_EN
       ,.mode224        (mode224)
`endif
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] sha_iv(input logic m256);
        logic [7:0][31:0] v;
        for (int i = 0; i < 8; i++) v[i] = m256 ? Iv256[i] : Iv224[i];
        return v;
    endfunction

    function automatic logic [7:0][31:0] sha_compress(input logic [7:0][31:0] hin,
                                                      input logic [15:0][31:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [7:0][31:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            w[i] = w[i-16] + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        end
        a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
        e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        hout[0] = hin[0] + a; hout[1] = hin[1] + b; hout[2] = hin[2] + c; hout[3] = hin[3] + d;
        hout[4] = hin[4] + e; hout[5] = hin[5] + f; hout[6] = hin[6] + g; hout[7] = hin[7] + h;
        return hout;
    endfunction

    // Core stub: block/ctrl registers, compute latency, optional never-ready hang.
    logic [15:0][31:0] c_block;
    logic [7:0][31:0]  c_h;
    logic              c_ready;
    int                c_busy;
    bit                c_hang = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            c_ready <= 1'b1;
            c_busy  <= 0;
        end else begin
            if (c_busy > 0) begin
                c_busy <= c_busy - 1;
                if (c_busy == 1) c_ready <= 1'b1;
            end
            if (sha_cs && sha_we) begin
                if (sha_address[7:4] == 4'h1) begin
                    c_block[sha_address[3:0]] <= sha_write_data;
                end else if (sha_address == 8'h08 && (sha_write_data[0] || sha_write_data[1])) begin
                    c_h <= sha_compress(sha_write_data[0] ? sha_iv(sha_write_data[2]) : c_h, c_block);
                    c_ready <= 1'b0;
                    c_busy  <= c_hang ? 0 : CoreLatency;
                end
            end
        end
    end

    always_comb begin
        sha_read_data = '0;
        if (sha_cs && !sha_we) begin
            if (sha_address == 8'h09) sha_read_data = {31'b0, c_ready};
            else if (sha_address[7:3] == 5'b00100) sha_read_data = c_h[sha_address[2:0]];
        end
    end

    int           n_checks = 0;
    int           n_errors = 0;
    logic [39:0]  exp_wr [$];
    logic [32:0]  exp_dig [$];
    int           dig_seen = 0;
    int           poll_cnt = 0;
    int           rd_cnt [8];
    bit           hold_prev = 1'b0;
    logic [31:0]  hold_data = '0;
    logic [15:0][31:0] b_abc, b_two1, b_two2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [39:0] w;
        logic [32:0] d;
        if (sha_cs && sha_we) begin
            n_checks++;
            assert (exp_wr.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected none",
                       sha_address, sha_write_data);
            end
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                check("bus_write", {24'b0, sha_address, sha_write_data}, {24'b0, w});
            end
        end
        if (sha_cs && !sha_we) begin
            if (sha_address == 8'h09) poll_cnt++;
            if (sha_address[7:3] == 5'b00100) rd_cnt[sha_address[2:0]]++;
        end
        if (hold_prev) begin
            check("hold_valid", {63'b0, dig_valid}, 64'd1);
            check("hold_data", {32'b0, dig_data}, {32'b0, hold_data});
        end
        if (dig_valid && dig_ready) begin
            n_checks++;
            assert (exp_dig.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_digest: observed %0h expected none", dig_data);
            end
            if (exp_dig.size() != 0) begin
                d = exp_dig.pop_front();
                check("digest_word", {32'b0, dig_data}, {32'b0, d[31:0]});
                check("digest_last", {63'b0, dig_last}, {63'b0, d[32]});
            end
            dig_seen++;
        end
        hold_prev = dig_valid && !dig_ready;
        hold_data = dig_data;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [15:0][31:0] blk, input bit first, input bit last,
                              input bit noise, input int nwords, input logic [31:0] ctrl);
        int n;
        for (int k = 0; k < nwords; k++) begin
            in_valid = 1'b1;
            in_data  = blk[k];
            in_first = (k == 0) ? first : noise;
            in_last  = (k == 15) ? last : noise;
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            check("in_ready_wait", {63'b0, in_ready}, 64'd1);
            exp_wr.push_back({8'h10 + 8'(k), blk[k]});
            tick();
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        if (nwords == 16) exp_wr.push_back({8'h08, ctrl});
    endtask

    task automatic push_digest(input logic [0:7][31:0] dg, input int n);
        for (int i = 0; i < n; i++) exp_dig.push_back({i == n - 1, dg[i]});
    endtask

    task automatic wait_done(input int stall_at, input int stall_len);
        int n = 0;
        int left = stall_len;
        while (busy && n < Budget) begin
            if (dig_valid && dig_seen == stall_at && left > 0) begin
                dig_ready = 1'b0;
                left--;
            end else begin
                dig_ready = 1'b1;
            end
            tick();
            n++;
        end
        dig_ready = 1'b1;
        check("done_in_budget", {63'b0, busy}, 64'd0);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("dig_queue_drained", 64'(exp_dig.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_err", {63'b0, err}, 64'd0);
        check("rst_bus", {22'b0, sha_cs, sha_we, sha_address, sha_write_data}, 64'd0);
        check("rst_dig", {30'b0, dig_valid, dig_last, dig_data}, 64'd0);
    endtask

    initial begin
        int seen_before;
        b_abc = '0;
        b_abc[0] = 32'h61626380;
        b_abc[15] = 32'h00000018;
        b_two1 = {32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70,
                  32'h6c6d6e6f, 32'h6b6c6d6e, 32'h6a6b6c6d, 32'h696a6b6c,
                  32'h68696a6b, 32'h6768696a, 32'h66676869, 32'h65666768,
                  32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364};
        b_two2 = '0;
        b_two2[15] = 32'h000001c0;

        // Reset state and in_ready release timing.
        tick(); tick(); tick();
        check_reset_outputs();
        reset = 1'b0;
        check("in_ready_before_release", {63'b0, in_ready}, 64'd0);
        tick();
        check("in_ready_after_release", {63'b0, in_ready}, 64'd1);

        // First block with in_first=0 straight after reset still uses init.
        send_block(b_abc, 1'b0, 1'b1, 1'b0, 16, 32'h05);
        push_digest(DigAbc, 8);
        wait_done(-1, 0);
        check("err_clean", {63'b0, err}, 64'd0);

        // Single-block "abc" with first=last=1.
        send_block(b_abc, 1'b1, 1'b1, 1'b0, 16, 32'h05);
        push_digest(DigAbc, 8);
        wait_done(-1, 0);

        // Two-block message; flags outside their sampling words are driven high and ignored.
        seen_before = dig_seen;
        send_block(b_two1, 1'b1, 1'b0, 1'b1, 16, 32'h05);
        wait_done(-1, 0);
        check("no_digest_mid_chain", 64'(dig_seen), 64'(seen_before));
        for (int i = 0; i < 8; i++) rd_cnt[i] = 0;
        send_block(b_two2, 1'b0, 1'b1, 1'b1, 16, 32'h06);
        push_digest(DigTwo, 8);
        wait_done(3, 10);
        check("single_read_0x23", 64'(rd_cnt[3]), 64'd1);
        check("dig_count", 64'(dig_seen), 64'(seen_before + 8));

        // Core never ready: watchdog expires after Timeout polls.
        c_hang = 1'b1;
        poll_cnt = 0;
        send_block(b_abc, 1'b1, 1'b1, 1'b0, 16, 32'h05);
        wait_done(-1, 0);
        check("timeout_err", {63'b0, err}, 64'd1);
        check("timeout_polls", 64'(poll_cnt), 64'(Timeout));
        check("timeout_in_ready", {63'b0, in_ready}, 64'd1);
        c_hang = 1'b0;

        // Reset after 7 loaded words aborts; next block restarts at 0x10 with init.
        send_block(b_abc, 1'b1, 1'b1, 1'b0, 7, 32'h0);
        reset = 1'b1;
        tick();
        check_reset_outputs();
        check("abort_wr_queue", 64'(exp_wr.size()), 64'd0);
        reset = 1'b0;
        tick();
        send_block(b_abc, 1'b0, 1'b1, 1'b0, 16, 32'h05);
        push_digest(DigAbc, 8);
        wait_done(-1, 0);

`ifdef SHA_SEQ_MODE224_EN
        mode224 = 1'b1;
        send_block(b_abc, 1'b1, 1'b1, 1'b0, 16, 32'h01);
        push_digest(Dig224, 7);
        wait_done(-1, 0);
        mode224 = 1'b0;
`endif

        // A core bus error sets the sticky flag without starting anything.
        check("err_before_pulse", {63'b0, err}, 64'd0);
        sha_error = 1'b1;
        tick();
        sha_error = 1'b0;
        tick();
        check("err_sticky", {63'b0, err}, 64'd1);
        check("idle_after_error", {63'b0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sha_seq.md
# sha_seq

Block sequencer for the `sha256` core. It accepts 512-bit message blocks as a stream of sixteen 32-bit words and writes them into the core's block registers over its `cs`/`we`/`address` register bus. It then issues init/next, polls status until the core is ready, and streams the digest out for the last block of a message. It sits between a host/DMA-side word stream and `sha256`, inside the selected-clock domain.

## Interface
- `POLL_TIMEOUT`, default 255: max status-poll cycles before timeout error (1..65535).
- `clk` in 1: clock (the muxed core clock).
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: sequencer accepts a word.
- `in_data` in 32: block word, big-endian word order (word 0 first).
- `in_first` in 1: sampled with word 0; block starts a new message.
- `in_last` in 1: sampled with word 15; block ends the message.
- `dig_valid` out 1: digest word valid.
- `dig_ready` in 1: consumer accepts digest word.
- `dig_data` out 32: digest word, word 0 first.
- `dig_last` out 1: final digest word.
- `busy` out 1: state != IDLE.
- `err` out 1: sticky error (core `error` seen or poll timeout); cleared only by reset.
- `sha_cs`, `sha_we` out 1: core bus controls, registered.
- `sha_address` out 8: core bus address, registered.
- `sha_write_data` out 32: core bus write data, registered.
- `sha_read_data` in 32: core read data, combinational from core.
- `sha_error` in 1: core bus error.
- `mode224` in 1: only with `SHA_SEQ_MODE224_EN`.

## Operation
- Core map: CTRL 0x08 (bit0 init, bit1 next, bit2 mode: 1 = SHA-256); STATUS 0x09 (bit0 ready); BLOCK 0x10..0x1F; DIGEST 0x20..0x27.
- States:
  - IDLE/LOAD: `in_ready`=1.
    - Each accepted word k (counter 0..15) issues a write next cycle: `sha_cs`=1, `sha_we`=1, `sha_address`=0x10+k, `sha_write_data`=word.
    - Word 0 latches `in_first`; word 15 latches `in_last` → CTRL.
  - CTRL: one write to 0x08: init if the latched first flag is set OR no message is open, else next; mode bit per configuration. Sets chain_open.
  - SETTLE: 2 idle cycles so the core's ready drops.
  - POLL: status read every cycle. Ready=1 → DRD if last else IDLE. Watchdog reaches `POLL_TIMEOUT` → set `err`, clear chain_open, go to IDLE.
  - DRD: read 0x20+d, capture `sha_read_data` at the end of that cycle → DOUT.
  - DOUT: `dig_valid`=1 until `dig_ready`; d==N-1 → `dig_last`=1, clear chain_open, go to IDLE; else d+1 → DRD.
- `in_first` on words 1..15 and `in_last` on words 0..14 are ignored.
- `sha_error`=1 in any cycle sets `err`; sequencing continues.
- N=8 digest words (7 in SHA-224 mode).

## Timing
- Reset values: all outputs 0, counters 0, chain_open 0, state IDLE; `in_ready` rises the cycle after reset deasserts.
- Reset mid-operation aborts immediately; no further bus access. The next block starts at 0x10 and always uses init.
- Load: 1 word/cycle under full `in_valid`. The write appears one cycle after acceptance.
- The CTRL write occurs the cycle after the word-15 write. First poll: 3 cycles after CTRL.
- Digest: ≥2 cycles per word. `dig_data` is held stable while `dig_valid`&!`dig_ready`.
- Block-to-accept latency excluding core compute: 16 + 1 + 2 + polls.
- Bus outputs are a single access per cycle; `sha_cs`=0 in IDLE-without-input, SETTLE and DOUT.

## Configuration
- `SHA_SEQ_MODE224_EN` defined:
  - `mode224` port exists, latched with word 0 of a message that opens a chain.
  - When set: CTRL bit2=0 and N=7.
- Undefined: no port, bit2=1, N=8.

## Structure
- Shared package `sha_seq_pkg`: core address constants, CTRL bit indices, state enum, digest word counts.
- One natural sub-module: `sha_seq_watchdog`, a poll-cycle counter with clear/enable/expired, sized by `POLL_TIMEOUT`.

## Test plan
- Single-block "abc" (words 0x61626380, 0×14, 0x00000018; first=last=1):
  - CTRL write 0x05.
  - Digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; `dig_last` on word 8.
- Two-block "abcdbcdecdefdefg…nopq" (448 bits):
  - CTRL 0x05 then 0x06; no digest after block 1.
  - Digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- First block with `in_first`=0 after reset → CTRL 0x05 (forced init).
- `dig_ready` low 10 cycles on word 3 → `dig_data` and `dig_valid` stable; no extra reads to 0x23.
- Core stub never ready, `POLL_TIMEOUT`=4 → `err`=1 after 4 polls; returns to IDLE with `in_ready`=1.
- Reset after 7 loaded words → all outputs 0 next cycle; the following block writes 0x10 first with CTRL 0x05.
- With macro, `mode224`=1, "abc" → CTRL 0x01; 7 words 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, `dig_last` on word 7.
